// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-MM burst master: FSM encodings,
// response codes and default widths.
package avalon_pkg;

  localparam int ADDR_W_DEF     = 13;
  localparam int DATA_W_DEF     = 32;
  localparam int LEN_W_DEF      = 10;
  localparam int MAX_BURST_DEF  = 256;
  localparam int FIFO_DEPTH_DEF = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_CMD  = 3'd1;
  localparam state_t ST_WR_BEAT = 3'd2;
  localparam state_t ST_RD_CMD  = 3'd3;
  localparam state_t ST_RD_DATA = 3'd4;
  localparam state_t ST_FINISH  = 3'd5;

endpackage

// File: rtl/burst_wr_fifo.sv
// Synchronous write-data FIFO. It shows the head word without a read
// latency and uses an extra pointer bit to tell full from empty.
module burst_wr_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head    = mem[rd_ptr[PTR_W-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/avalon_burst_master.sv
// Avalon-MM burst master that splits one command into bursts of at most MAX_BURST words.
// Define RESP_CHECK_EN to make a non-OKAY response on a data beat set the sticky error flag.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | wait for cmd_start
// WR_CMD     | first write cycle of a burst (beginbursttransfer with write)
// WR_BEAT    | remaining write beats, paced by FIFO data and waitrequest
// RD_CMD     | read request held until the slave accepts it
// RD_DATA    | collect blen readdatavalid beats
// FINISH     | one-cycle done pulse
module avalon_burst_master
  import avalon_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_start,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] address,
  output logic [LEN_W-1:0]  burstcount,
  output logic              beginbursttransfer,
  output logic              write,
  output logic              read,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              readdatavalid,
  input  logic              waitrequest,
  input  logic [1:0]        response
);

  localparam logic [LEN_W-1:0] MAX_BLEN = LEN_W'(MAX_BURST);

  function automatic logic [LEN_W-1:0] clip_len(input logic [LEN_W-1:0] n);
    return (n > MAX_BLEN) ? MAX_BLEN : n;
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [LEN_W-1:0]  blen_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic              first_q;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_phase;
  logic              bus_active;
  logic              wr_accept;
  logic              rd_beat;
  logic              beat_step;
  logic              burst_last;
  logic              stray_rdv;
  logic              resp_bad;
  logic [LEN_W-1:0]  rem_after;
  logic [LEN_W-1:0]  blen_after;

  burst_wr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (wr_valid && !fifo_full),
    .push_data (wr_data),
    .pop       (wr_accept),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_phase           = (state == ST_WR_CMD) || (state == ST_WR_BEAT);
  assign write              = wr_phase && !fifo_empty;
  assign read               = (state == ST_RD_CMD);
  // The burst marker goes with the first cycle that write is up, even if that beat is stalled.
  assign beginbursttransfer = ((state == ST_WR_CMD) && !fifo_empty) || (read && first_q);
  assign bus_active         = write || read;
  assign address            = bus_active ? addr_q : '0;
  assign burstcount         = bus_active ? blen_q : '0;
  assign writedata          = write ? fifo_head : '0;
  assign wr_ready           = !fifo_full;
  assign busy               = (state != ST_IDLE) && (state != ST_FINISH);
  assign done               = (state == ST_FINISH);

  assign wr_accept  = write && !waitrequest;
  assign rd_beat    = (state == ST_RD_DATA) && readdatavalid;
  assign beat_step  = wr_accept || rd_beat;
  assign burst_last = beat_step && (beat_cnt == LEN_W'(1));
  assign rem_after  = rem_q - blen_q;
  assign blen_after = clip_len(rem_after);
  assign stray_rdv  = readdatavalid && (state != ST_RD_DATA);

`ifdef RESP_CHECK_EN
  assign resp_bad = (wr_accept || readdatavalid) && (response != RESP_OKAY);
`else
  logic unused_response;
  assign unused_response = ^response;
  assign resp_bad        = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      blen_q   <= '0;
      beat_cnt <= '0;
      first_q  <= 1'b0;
      error    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_beat;
      if (rd_beat) rd_data <= readdata;

      case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            error <= 1'b0;
            if (cmd_len == '0) begin
              state <= ST_FINISH;
            end else begin
              addr_q   <= cmd_addr;
              rem_q    <= cmd_len;
              blen_q   <= clip_len(cmd_len);
              beat_cnt <= clip_len(cmd_len);
              first_q  <= !cmd_write;
              state    <= cmd_write ? ST_WR_CMD : ST_RD_CMD;
            end
          end
        end
        ST_WR_CMD: begin
          if (write) state <= ST_WR_BEAT;
        end
        ST_RD_CMD: begin
          first_q <= 1'b0;
          if (!waitrequest) state <= ST_RD_DATA;
        end
        ST_FINISH: state <= ST_IDLE;
        ST_WR_BEAT, ST_RD_DATA: ;
        default: state <= ST_IDLE;
      endcase

      // End of burst overrides the per-state transitions above.
      if (beat_step) begin
        if (burst_last) begin
          addr_q   <= addr_q + ADDR_W'(blen_q);
          rem_q    <= rem_after;
          blen_q   <= blen_after;
          beat_cnt <= blen_after;
          if (rem_after == '0) begin
            state <= ST_FINISH;
          end else if (state == ST_RD_DATA) begin
            state   <= ST_RD_CMD;
            first_q <= 1'b1;
          end else begin
            state <= ST_WR_CMD;
          end
        end else begin
          beat_cnt <= beat_cnt - LEN_W'(1);
        end
      end

      if (stray_rdv || resp_bad) error <= 1'b1;
    end
  end

endmodule
